sram_bridge: RTL and testbench

//  Wait-state bridge between the 6502 bus and the external asynchronous SRAM in the CPU page-3 window (0x3000-0x3FFF).

---
 rtl/sram_bridge.sv | 137 +++++++++++++
 tb/tb_sram_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bridge.sv
// -----------------------------------------------------------------------------
// sram_bridge
//   Wait-state bridge between the 6502 bus and the external asynchronous SRAM
//   in the CPU page-3 window. Each access accepted in IDLE is stretched into
//   setup / strobe / hold phases on the SRAM pins. The CPU is stalled through
//   rdy, and read data is kept in a register for the top-level data mux.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | rdy=1, waiting for cs; latches ab/din/we on acceptance
//   SETUP  | ce_n low, address settles; oe_n low (read) or dq_oe (write)
//   STROBE | WAIT_CYCLES cycles of oe_n (read) or we_n (write) low
//   HOLD   | strobes released, ce_n still low, write data still driven
//   DONE   | rdy=1, everything released, cs ignored (request still on bus)
//
// Parameters
//   ADDR_W      SRAM address width
//   WAIT_CYCLES strobe length in clk cycles, legal range 1..15
//
// Ports
//   clk, reset           CPU clock, asynchronous active-high reset
//   cs, we, ab, din      CPU request: select, write enable, address, data
//   dout                 registered read data
//   rdy                  CPU RDY, low = stall
//   sram_addr            SRAM address
//   sram_dq_o/_oe/_i     SRAM data out, drive enable, data in
//   sram_ce_n/oe_n/we_n  SRAM strobes, active low
// -----------------------------------------------------------------------------
module sram_bridge #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] ab,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              rdy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       dir, dir_nx;          // 1 = write access
    logic       accept, capture;
    logic       ce_n_nx, oe_n_nx, we_n_nx, dq_oe_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dir_nx   = dir;
        accept   = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (cs) begin
                    accept   = 1'b1;
                    dir_nx   = we;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                cnt_nx   = CNT_LOAD;
                state_nx = STROBE;
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    capture  = ~dir;
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            HOLD:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Strobes are decoded from the next state so that the pin registers
        // line up exactly with the state register.
        ce_n_nx  = ~(state_nx inside {SETUP, STROBE, HOLD});
        oe_n_nx  = ~(~dir_nx && (state_nx inside {SETUP, STROBE}));
        we_n_nx  = ~(dir_nx && (state_nx == STROBE));
        dq_oe_nx = dir_nx && (state_nx inside {SETUP, STROBE, HOLD});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            dir        <= 1'b0;
            dout       <= 8'h00;
            sram_addr  <= '0;
            sram_dq_o  <= 8'h00;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            dir        <= dir_nx;
            sram_ce_n  <= ce_n_nx;
            sram_oe_n  <= oe_n_nx;
            sram_we_n  <= we_n_nx;
            sram_dq_oe <= dq_oe_nx;
            if (accept) begin
                sram_addr <= ab;
                sram_dq_o <= din;
            end
            if (capture) begin
                dout <= sram_dq_i;
            end
        end
    end

    assign rdy = (state == IDLE) || (state == DONE);

endmodule

// File: tb/tb_sram_bridge.sv
module tb_sram_bridge;

    logic        clk = 1'b0;
    logic        reset;
    int          errors = 0;
    int          checks = 0;

    // W=2 instance
    logic        cs, we;
    logic [11:0] ab;
    logic [7:0]  din, dout, sram_dq_o, sram_dq_i;
    logic        rdy, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [11:0] sram_addr;

    // W=1 instance
    logic        cs1, we1;
    logic [11:0] ab1;
    logic [7:0]  din1, dout1, sram_dq_o1, sram_dq_i1;
    logic        rdy1, sram_dq_oe1, sram_ce_n1, sram_oe_n1, sram_we_n1;
    logic [11:0] sram_addr1;

    logic [7:0]  mem  [0:4095];   // behavioural SRAM on the W=2 pins
    logic [7:0]  refm [0:4095];   // bench expectation of SRAM contents

    always #5 clk = ~clk;

    sram_bridge #(.ADDR_W(12), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .ab(ab), .din(din),
        .dout(dout), .rdy(rdy), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    sram_bridge #(.ADDR_W(12), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .cs(cs1), .we(we1), .ab(ab1), .din(din1),
        .dout(dout1), .rdy(rdy1), .sram_addr(sram_addr1), .sram_dq_o(sram_dq_o1),
        .sram_dq_oe(sram_dq_oe1), .sram_dq_i(sram_dq_i1), .sram_ce_n(sram_ce_n1),
        .sram_oe_n(sram_oe_n1), .sram_we_n(sram_we_n1)
    );

    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;

    assign sram_dq_i  = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;
    assign sram_dq_i1 = (!sram_ce_n1 && !sram_oe_n1) ? (sram_addr1[7:0] ^ 8'h3C) : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One access on u0. Returns per-signal active-cycle counts between
    // acceptance and DONE, plus dout as seen in DONE.
    task automatic access(input logic w, input logic [11:0] a, input logic [7:0] d,
                          output int n_rdy, output int n_oe, output int n_we,
                          output int n_dqoe, output logic [7:0] dout_done);
        n_rdy = 0; n_oe = 0; n_we = 0; n_dqoe = 0;
        @(negedge clk);
        cs = 1'b1; we = w; ab = a; din = d;
        @(negedge clk);
        cs = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (rdy) break;
            n_rdy++;
            if (!sram_oe_n) n_oe++;
            if (!sram_we_n) n_we++;
            if (sram_dq_oe) n_dqoe++;
            chk("no_oe_we_overlap", 32'(!sram_oe_n && !sram_we_n), 0);
            chk("no_dqoe_in_read",  32'(sram_dq_oe && !sram_oe_n), 0);
            chk("addr_stable",      32'(sram_addr), 32'(a));
            if (w) chk("wdata_stable", 32'(sram_dq_o), 32'(d));
        end
        chk("done_rdy",   32'(rdy), 1);
        chk("done_ce_n",  32'(sram_ce_n), 1);
        chk("done_dq_oe", 32'(sram_dq_oe), 0);
        dout_done = dout;
    endtask

    initial begin
        int          nr, no, nw, nd;
        logic [7:0]  dd, last_rd;
        logic        rdy_log [0:11];
        logic        ce_log  [0:11];
        logic [7:0]  dout_log [0:11];
        int          first_setup, second_setup;
        logic        w;
        logic [11:0] a;
        logic [7:0]  d;

        for (int i = 0; i < 4096; i++) begin
            mem[i]  = 8'(i) ^ 8'h5A;
            refm[i] = 8'(i) ^ 8'h5A;
        end
        mem[12'h123]  = 8'hA5;
        refm[12'h123] = 8'hA5;

        reset = 1'b1;
        cs = 0; we = 0; ab = 0; din = 0;
        cs1 = 0; we1 = 0; ab1 = 0; din1 = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_rdy",    32'(rdy), 1);
        chk("rst_ce_n",   32'(sram_ce_n), 1);
        chk("rst_oe_n",   32'(sram_oe_n), 1);
        chk("rst_we_n",   32'(sram_we_n), 1);
        chk("rst_dq_oe",  32'(sram_dq_oe), 0);
        chk("rst_dout",   32'(dout), 0);
        chk("rst_addr",   32'(sram_addr), 0);
        chk("rst_dq_o",   32'(sram_dq_o), 0);

        // Directed read
        access(1'b0, 12'h123, 8'h00, nr, no, nw, nd, dd);
        chk("rd_rdy_low", nr, 4);
        chk("rd_oe_low",  no, 3);
        chk("rd_we_low",  nw, 0);
        chk("rd_dq_oe",   nd, 0);
        chk("rd_dout",    32'(dd), 32'hA5);

        // Directed write
        access(1'b1, 12'h0FF, 8'h5A, nr, no, nw, nd, dd);
        refm[12'h0FF] = 8'h5A;
        chk("wr_rdy_low", nr, 4);
        chk("wr_we_low",  nw, 2);
        chk("wr_dq_oe",   nd, 4);
        chk("wr_oe_low",  no, 0);
        chk("wr_dq_o",    32'(sram_dq_o), 32'h5A);
        chk("wr_dout",    32'(dd), 32'hA5);
        chk("wr_mem",     32'(mem[12'h0FF]), 32'h5A);

        // cs held high through DONE: the second access starts only from IDLE
        @(negedge clk);
        cs = 1'b1; we = 1'b0; ab = 12'h123;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rdy_log[i] = rdy;
            ce_log[i]  = sram_ce_n;
        end
        cs = 1'b0;
        chk("csh_setup_rdy", 32'(rdy_log[0]), 0);
        chk("csh_done_rdy",  32'(rdy_log[4]), 1);
        chk("csh_done_ce",   32'(ce_log[4]), 1);
        chk("csh_idle_rdy",  32'(rdy_log[5]), 1);
        chk("csh_idle_ce",   32'(ce_log[5]), 1);
        chk("csh_second",    32'(rdy_log[6]), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy) break;
        end
        chk("csh_end_rdy", 32'(rdy), 1);

        // Reset during the second STROBE cycle of a write
        @(negedge clk);
        cs = 1'b1; we = 1'b1; ab = 12'h050; din = 8'h77;
        @(negedge clk);           // SETUP
        cs = 1'b0;
        @(negedge clk);           // STROBE 1
        @(posedge clk);           // enter STROBE 2
        #1;
        chk("pre_rst_we_n", 32'(sram_we_n), 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_we_n",  32'(sram_we_n), 1);
        chk("mid_rst_ce_n",  32'(sram_ce_n), 1);
        chk("mid_rst_dq_oe", 32'(sram_dq_oe), 0);
        chk("mid_rst_rdy",   32'(rdy), 1);
        chk("mid_rst_dout",  32'(dout), 0);
        @(negedge clk);
        reset = 1'b0;
        refm[12'h050] = 8'h77;    // we_n was low across one edge before reset
        @(negedge clk);
        chk("post_rst_rdy",  32'(rdy), 1);
        chk("post_rst_ce_n", 32'(sram_ce_n), 1);

        // W=1 back-to-back reads of 0x001 then 0x002 with cs held high
        @(negedge clk);
        cs1 = 1'b1; we1 = 1'b0; ab1 = 12'h001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) ab1 = 12'h002;
            rdy_log[i]  = rdy1;
            dout_log[i] = dout1;
        end
        cs1 = 1'b0;
        first_setup = -1; second_setup = -1;
        for (int i = 0; i < 10; i++) begin
            if (!rdy_log[i] && (i == 0 || rdy_log[i-1])) begin
                if (first_setup < 0) first_setup = i;
                else if (second_setup < 0) second_setup = i;
            end
        end
        nr = 0;
        for (int i = 0; i < 4; i++) if (!rdy_log[i]) nr++;
        chk("w1_stall1", nr, 3);
        nr = 0;
        for (int i = 5; i < 9; i++) if (!rdy_log[i]) nr++;
        chk("w1_stall2", nr, 3);
        chk("w1_dout1",   32'(dout_log[3]), 32'h3D);
        chk("w1_hold1",   32'(dout_log[4]), 32'h3D);
        chk("w1_dout2",   32'(dout_log[8]), 32'h3E);
        chk("w1_spacing", second_setup - first_setup, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy1) break;
        end

        // Random stream against the behavioural SRAM
        last_rd = dout;
        for (int t = 0; t < 1000; t++) begin
            w = 1'($urandom_range(0, 1));
            a = 12'($urandom_range(0, 31));
            d = 8'($urandom_range(0, 255));
            access(w, a, d, nr, no, nw, nd, dd);
            if (w) begin
                refm[a] = d;
                chk("rand_wr_dout", 32'(dd), 32'(last_rd));
            end else begin
                chk("rand_rd", 32'(dd), 32'(refm[a]));
                last_rd = refm[a];
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 32; i++) chk("rand_mem", 32'(mem[i]), 32'(refm[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
